mem_access_ctrl: RTL

- Parametrised MEM-stage access controller between the EX/MEM pipeline register and the SRAM/memory-control unit.
- Replaces the single-cycle pass-through MEM stage with a handshaked multi-cycle access FSM that:
  - registers address, write-enable and store data for the access;
  - waits for the memory controller's acknowledge;
  - captures load data;
  - stalls the pipeline for the access duration;
  - aborts with a bus-error pulse on timeout.

---
 rtl/mem_access_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: turns an EX/MEM load/store into a handshaked
// request to the memory controller, stalling the pipeline until ack or timeout.
//
// state | meaning
// IDLE  | no access in flight; non-memory ops pass straight through
// BUSY  | request held to memory control, waiting for ack or timeout
// DONE  | access finished; writeback presented, pipeline released
module mem_access_ctrl #(
   parameter int                 DATA_W     = 16,
   parameter int                 ADDR_W     = 16,
   parameter int                 REG_ADDR_W = 4,
   parameter int                 TIMEOUT    = 15,
   parameter logic [DATA_W-1:0]  ERR_DATA   = 16'hFFFF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     mem_addr_i,
   input  logic                  r_mem_i,
   input  logic                  w_mem_i,
   input  logic [DATA_W-1:0]     store_data_i,
   input  logic [DATA_W-1:0]     alu_data_i,
   input  logic                  w_reg_i,
   input  logic [REG_ADDR_W-1:0] w_reg_addr_i,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   input  logic [DATA_W-1:0]     mem_rdata_i,
   input  logic                  mem_ack_i,
   output logic [DATA_W-1:0]     w_data_o,
   output logic                  w_reg_o,
   output logic [REG_ADDR_W-1:0] w_reg_addr_o,
   output logic                  stall_request,
   output logic                  bus_err_o
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   // Counter holds (BUSY cycles so far - 1), so the last allowed cycle is TIMEOUT-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rdata_q;
   logic              load_q;
   logic              access;
   logic              timed_out;

   assign access    = r_mem_i | w_mem_i;
   assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         rdata_q     <= '0;
         load_q      <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         bus_err_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus_err_o <= 1'b0;
               if (access) begin
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= w_mem_i & ~r_mem_i;
                  mem_addr_o  <= mem_addr_i;
                  mem_wdata_o <= store_data_i;
                  load_q      <= r_mem_i;
                  cnt         <= '0;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
               if (mem_ack_i) begin
                  if (load_q) rdata_q <= mem_rdata_i;
                  mem_req_o <= 1'b0;
                  state     <= DONE;
               end else if (timed_out) begin
                  rdata_q   <= ERR_DATA;
                  bus_err_o <= 1'b1;
                  mem_req_o <= 1'b0;
                  state     <= DONE;
               end
            end
            DONE: begin
               bus_err_o <= 1'b0;
               cnt       <= '0;
               state     <= IDLE;
            end
            default: begin
               mem_req_o <= 1'b0;
               bus_err_o <= 1'b0;
               cnt       <= '0;
               state     <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      stall_request = ((state == IDLE) && access) || (state == BUSY);
      w_reg_o       = stall_request ? 1'b0 : w_reg_i;
      w_reg_addr_o  = w_reg_addr_i;
      w_data_o      = ((state == DONE) && load_q) ? rdata_q : alu_data_i;
   end

endmodule
